// File: rtl/q_meas_pkg.sv
// Shared types and defaults for the measurement-result register and its wait timer.
package q_meas_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam int DEF_NUM_QUBITS = 8;
   localparam int DEF_TIMEOUT    = 1023;
   localparam int TIMER_W        = $clog2(DEF_TIMEOUT + 1);

endpackage

// File: rtl/q_meas_reg_wait_timer.sv
// Wait-cycle counter: cleared when a read misses, counts while waiting, flags LIMIT.
module wait_timer
   import q_meas_pkg::*;
#(
   parameter int LIMIT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_done
);

   localparam logic [TIMER_W-1:0] LIMIT_V = TIMER_W'(LIMIT);

   logic [TIMER_W-1:0] r_count;

   // Saturates at LIMIT so a late enable can never wrap past the abort point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_done) begin
         r_count <= r_count + TIMER_W'(1);
      end
   end

   assign o_done = (r_count == LIMIT_V);

endmodule

// File: rtl/q_meas_reg.sv
// Per-qubit measurement result store with a blocking read that stalls the core until
// the requested result arrives or the wait times out.
module q_meas_reg
   import q_meas_pkg::*;
#(
   parameter int NUM_QUBITS = DEF_NUM_QUBITS,
   parameter int QIDX_W     = 3,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_meas_issue,
   input  logic [QIDX_W-1:0]     i_issue_qidx,
   input  logic                  i_meas_valid,
   input  logic [QIDX_W-1:0]     i_meas_qidx,
   input  logic                  i_meas_bit,
   input  logic                  i_rd_req,
   input  logic [QIDX_W-1:0]     i_rd_qidx,
   output logic                  o_stall,
   output logic                  o_rd_valid,
   output logic [63:0]           o_rd_data,
   output logic                  o_timeout,
   output logic [NUM_QUBITS-1:0] o_valid_vec
);

   state_t                r_state;
   logic [QIDX_W-1:0]     r_qidx;
   logic [NUM_QUBITS-1:0] r_res;
   logic [NUM_QUBITS-1:0] r_val;
   logic                  r_rd_valid;
   logic                  r_rd_bit;
   logic                  r_timeout;

   logic w_in_wait;
   logic w_byp;
   logic w_hit;
   logic w_hit_bit;
   logic w_miss;
   logic w_match;
   logic w_timer_done;

   assign w_in_wait = (r_state == S_WAIT);
   assign w_byp     = i_meas_valid && (i_meas_qidx == i_rd_qidx);
   assign w_hit     = r_val[i_rd_qidx] || w_byp;
   // A result arriving this cycle is fresher than the stored bit.
   assign w_hit_bit = w_byp ? i_meas_bit : r_res[i_rd_qidx];
   assign w_miss    = !w_in_wait && i_rd_req && !w_hit;
   assign w_match   = i_meas_valid && (i_meas_qidx == r_qidx);

   assign o_stall     = rst_n && (w_in_wait || w_miss);
   assign o_rd_valid  = r_rd_valid;
   assign o_rd_data   = {63'b0, r_rd_bit};
   assign o_timeout   = r_timeout;
   assign o_valid_vec = r_val;

   wait_timer #(
      .LIMIT(TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_miss),
      .i_enable(w_in_wait),
      .o_done  (w_timer_done)
   );

   // Issue is applied after the result so a same-cycle issue leaves val cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res <= '0;
         r_val <= '1;
      end else begin
         for (int q = 0; q < NUM_QUBITS; q++) begin
            if (i_meas_valid && (i_meas_qidx == QIDX_W'(q))) begin
               r_res[q] <= i_meas_bit;
               r_val[q] <= 1'b1;
            end
            if (i_meas_issue && (i_issue_qidx == QIDX_W'(q))) begin
               r_val[q] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_qidx     <= '0;
         r_rd_valid <= 1'b0;
         r_rd_bit   <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_rd_bit   <= 1'b0;
         r_timeout  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_rd_req) begin
                  if (w_hit) begin
                     r_rd_valid <= 1'b1;
                     r_rd_bit   <= w_hit_bit;
                  end else begin
                     r_qidx  <= i_rd_qidx;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (w_match) begin
                  r_rd_valid <= 1'b1;
                  r_rd_bit   <= i_meas_bit;
                  r_state    <= S_IDLE;
               end else if (w_timer_done) begin
                  r_rd_valid <= 1'b1;
                  r_timeout  <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_q_meas_reg.sv
// Directed and random checks of q_meas_reg against a cycle-level behavioural model.
module tb_q_meas_reg;

   localparam int NQ  = 8;
   localparam int TMO = 4;

   logic        clk;
   logic        rst_n;
   logic        i_meas_issue;
   logic [2:0]  i_issue_qidx;
   logic        i_meas_valid;
   logic [2:0]  i_meas_qidx;
   logic        i_meas_bit;
   logic        i_rd_req;
   logic [2:0]  i_rd_qidx;
   logic        o_stall;
   logic        o_rd_valid;
   logic [63:0] o_rd_data;
   logic        o_timeout;
   logic [7:0]  o_valid_vec;

   int checks;
   int failures;
   int stall_cnt;

   // Reference model: stored results, valid flags, and the pending blocking read.
   logic [7:0] res_m;
   logic [7:0] val_m;
   bit         waiting;
   int         wq;
   int         wcnt;

   q_meas_reg #(
      .NUM_QUBITS(NQ),
      .QIDX_W    (3),
      .TIMEOUT   (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_meas_issue(i_meas_issue),
      .i_issue_qidx(i_issue_qidx),
      .i_meas_valid(i_meas_valid),
      .i_meas_qidx (i_meas_qidx),
      .i_meas_bit  (i_meas_bit),
      .i_rd_req    (i_rd_req),
      .i_rd_qidx   (i_rd_qidx),
      .o_stall     (o_stall),
      .o_rd_valid  (o_rd_valid),
      .o_rd_data   (o_rd_data),
      .o_timeout   (o_timeout),
      .o_valid_vec (o_valid_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      res_m   = '0;
      val_m   = '1;
      waiting = 0;
      wq      = 0;
      wcnt    = 0;
   endtask

   task automatic idle_inputs();
      i_meas_issue = 1'b0;
      i_issue_qidx = '0;
      i_meas_valid = 1'b0;
      i_meas_qidx  = '0;
      i_meas_bit   = 1'b0;
      i_rd_req     = 1'b0;
      i_rd_qidx    = '0;
   endtask

   // Reset pulled low mid-cycle, held across one rising edge, then released.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      chk("rst_stall", o_stall, 0);
      chk("rst_rd_valid", o_rd_valid, 0);
      chk("rst_rd_data", o_rd_data, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_valid_vec", o_valid_vec, 8'hff);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_hold_rd_valid", o_rd_valid, 0);
      chk("rst_hold_stall", o_stall, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock cycle of stimulus; model predicts the stall now and registered outputs next.
   task automatic step(input bit iss, input int iq, input bit mv, input int mq,
                       input bit mb, input bit rd, input int rq);
      bit exp_stall;
      bit nv;
      bit nd;
      bit nt;
      @(negedge clk);
      i_meas_issue = iss;
      i_issue_qidx = 3'(iq);
      i_meas_valid = mv;
      i_meas_qidx  = 3'(mq);
      i_meas_bit   = mb;
      i_rd_req     = rd;
      i_rd_qidx    = 3'(rq);
      exp_stall = 0;
      nv = 0;
      nd = 0;
      nt = 0;
      if (!waiting) begin
         if (rd) begin
            if (val_m[rq] || (mv && mq == rq)) begin
               nv = 1;
               nd = (mv && mq == rq) ? mb : res_m[rq];
            end else begin
               exp_stall = 1;
               waiting   = 1;
               wq        = rq;
               wcnt      = 0;
            end
         end
      end else begin
         exp_stall = 1;
         if (mv && mq == wq) begin
            nv = 1;
            nd = mb;
            waiting = 0;
         end else if (wcnt == TMO) begin
            nv = 1;
            nt = 1;
            waiting = 0;
         end else begin
            wcnt++;
         end
      end
      if (mv) begin
         res_m[mq] = mb;
         val_m[mq] = 1'b1;
      end
      if (iss) val_m[iq] = 1'b0;
      #1;
      chk("stall", o_stall, 64'(exp_stall));
      stall_cnt += int'(o_stall);
      @(posedge clk);
      #1;
      chk("rd_valid", o_rd_valid, 64'(nv));
      chk("rd_data", o_rd_data, 64'(nd));
      chk("timeout", o_timeout, 64'(nt));
      chk("valid_vec", o_valid_vec, 64'(val_m));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      idle_inputs();
      model_reset();
      do_reset();

      // Read straight after reset: every qubit starts valid with result 0.
      step(0, 0, 0, 0, 0, 1, 3);
      idle(1);

      // Issue q2, read q2, result arrives five cycles after the read.
      step(1, 2, 0, 0, 0, 0, 0);
      stall_cnt = 0;
      step(0, 0, 0, 0, 0, 1, 2);
      idle(4);
      step(0, 0, 1, 2, 1, 0, 0);
      idle(1);
      chk("q2_stall_cycles", 64'(stall_cnt), 6);

      // Bypass hit: read q5 in the same cycle its result lands.
      step(1, 5, 0, 0, 0, 0, 0);
      stall_cnt = 0;
      step(0, 0, 1, 5, 1, 1, 5);
      idle(1);
      chk("q5_bypass_no_stall", 64'(stall_cnt), 0);

      // Timeout on q1, then a hit read shows the FSM is back in IDLE.
      step(1, 1, 0, 0, 0, 0, 0);
      stall_cnt = 0;
      step(0, 0, 0, 0, 0, 1, 1);
      idle(TMO + 1);
      chk("q1_timeout_stall_cycles", 64'(stall_cnt), TMO + 2);
      step(0, 0, 0, 0, 0, 1, 3);

      // Same-cycle issue and result on q0: result stored, valid stays low.
      step(1, 0, 1, 0, 1, 0, 0);
      chk("q0_val_cleared", 64'(o_valid_vec[0]), 0);
      step(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      step(0, 0, 1, 0, 0, 0, 0);
      idle(1);

      // Reset while waiting on q4.
      step(1, 4, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 4);
      idle(1);
      do_reset();
      idle(2);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, NQ - 1),
              $urandom_range(0, 2) == 0, $urandom_range(0, NQ - 1), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) == 0, $urandom_range(0, NQ - 1));
      end
      idle(TMO + 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
